// File: rtl/rv_hazard_ctrl.sv
// Scoreboard hazard/flush controller beside decode: per-register pending-writer
// counters gate issue on RAW; a small FSM flushes IF/ID after an EX redirect.
// Optional macro RV_HAZARD_WB_BYPASS_EN lets a dependent issue in the writeback cycle.
module rv_hazard_ctrl #(
  parameter int CNT_W        = 2,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] id_rd,
  input  logic       id_rd_we,
  input  logic       ex_redirect,
  input  logic       wb_valid,
  input  logic [4:0] wb_rd,
  output logic       issue,
  output logic       stall_if,
  output logic       bubble_id_ex,
  output logic       flush_if_id,
  output logic       fwd_rs1,
  output logic       fwd_rs2,
  output logic       sb_err,
  output logic       dbg_state
);

  // Handshake: issue is the only "accept" of the IF/ID instruction; when it is
  // low the instruction stays put (stall_if) or is discarded (redirect/flush).

  typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [3:0]       FLOAD   = 4'(FLUSH_CYCLES - 1);

  state_t           state, state_nxt;
  logic [3:0]       fcnt, fcnt_nxt;
  logic             flush_nxt;
  logic [CNT_W-1:0] cnt [32];

  logic byp1, byp2, pend1, pend2, haz, sat, idle, inc, dec;

`ifdef RV_HAZARD_WB_BYPASS_EN
  // The last outstanding writer is retiring right now: take its result from WB.
  assign byp1 = (id_rs1 != 5'd0) && (cnt[id_rs1] == CNT_ONE) && wb_valid && (wb_rd == id_rs1);
  assign byp2 = (id_rs2 != 5'd0) && (cnt[id_rs2] == CNT_ONE) && wb_valid && (wb_rd == id_rs2);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  assign pend1 = (id_rs1 != 5'd0) && (cnt[id_rs1] != '0) && !byp1;
  assign pend2 = (id_rs2 != 5'd0) && (cnt[id_rs2] != '0) && !byp2;
  assign haz   = id_valid && ((id_use_rs1 && pend1) || (id_use_rs2 && pend2));
  assign sat   = id_valid && id_rd_we && (id_rd != 5'd0) && (cnt[id_rd] == CNT_MAX);
  assign idle  = (state == IDLE);

  assign issue        = id_valid && !haz && !sat && !ex_redirect && idle;
  assign stall_if     = id_valid && (haz || sat) && !ex_redirect && idle;
  assign bubble_id_ex = !issue;
  assign fwd_rs1      = id_use_rs1 && byp1;
  assign fwd_rs2      = id_use_rs2 && byp2;
  assign dbg_state    = (state == FLUSH);

  assign inc = issue && id_rd_we && (id_rd != 5'd0);
  assign dec = wb_valid && (wb_rd != 5'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < 32; r++) cnt[r] <= '0;
      sb_err <= 1'b0;
    end else begin
      // An issue and a writeback on the same register cancel out.
      for (int r = 1; r < 32; r++) begin
        if (inc && (id_rd == 5'(r)) && !(dec && (wb_rd == 5'(r))))
          cnt[r] <= cnt[r] + CNT_ONE;
        else if (dec && (wb_rd == 5'(r)) && !(inc && (id_rd == 5'(r))) && (cnt[r] != '0))
          cnt[r] <= cnt[r] - CNT_ONE;
      end
      if (dec && (cnt[wb_rd] == '0)) sb_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      fcnt        <= 4'd0;
      flush_if_id <= 1'b0;
    end else begin
      state       <= state_nxt;
      fcnt        <= fcnt_nxt;
      flush_if_id <= flush_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    fcnt_nxt  = fcnt;
    flush_nxt = flush_if_id;
    case (state)
      IDLE: begin
        if (ex_redirect) begin
          state_nxt = FLUSH;
          fcnt_nxt  = FLOAD;
          flush_nxt = 1'b1;
        end
      end
      FLUSH: begin
        if (ex_redirect) begin
          fcnt_nxt = FLOAD;
        end else if (fcnt == 4'd0) begin
          state_nxt = IDLE;
          flush_nxt = 1'b0;
        end else begin
          fcnt_nxt = fcnt - 4'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        flush_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_rv_hazard_ctrl.sv
// Bench for rv_hazard_ctrl: directed scenarios plus random traffic against a
// behavioural model of pending-writer counts and remaining flush cycles.
module tb_rv_hazard_ctrl;
  localparam int CNT_W = 2;
  localparam int FLUSH_CYCLES = 2;
  localparam int CMAX = (1 << CNT_W) - 1;
`ifdef RV_HAZARD_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic id_valid = 1'b0, id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, id_rd_we = 1'b0;
  logic ex_redirect = 1'b0, wb_valid = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0, wb_rd = '0;
  logic issue, stall_if, bubble_id_ex, flush_if_id, fwd_rs1, fwd_rs2, sb_err, dbg_state;

  rv_hazard_ctrl #(.CNT_W(CNT_W), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_rd_we(id_rd_we),
    .ex_redirect(ex_redirect), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .issue(issue), .stall_if(stall_if), .bubble_id_ex(bubble_id_ex), .flush_if_id(flush_if_id),
    .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2), .sb_err(sb_err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Reference model: how many writes are outstanding per register, and how
  // many more cycles IF/ID must be flushed.
  int model_cnt [32];
  int flush_left;
  bit model_err;
  int tests = 0;
  int fails = 0;

  logic [6:0] obs, expv;
  assign obs = {issue, stall_if, bubble_id_ex, flush_if_id, fwd_rs1, fwd_rs2, sb_err};

  function automatic bit m_pend(input logic [4:0] r, output bit byp);
    byp = 1'b0;
    if (r == 5'd0) return 1'b0;
    if (BYP && model_cnt[r] == 1 && wb_valid && wb_rd == r) begin
      byp = 1'b1;
      return 1'b0;
    end
    return model_cnt[r] != 0;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) model_cnt[r] = 0;
    flush_left = 0;
    model_err = 1'b0;
  endtask

  task automatic set_in(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                        input logic u1, input logic u2, input logic [4:0] rd, input logic we,
                        input logic rdr, input logic wv, input logic [4:0] wr);
    bit b1, b2, p1, p2, hz, st, ei;
    @(negedge clk);
    id_valid = v; id_rs1 = r1; id_rs2 = r2; id_use_rs1 = u1; id_use_rs2 = u2;
    id_rd = rd; id_rd_we = we; ex_redirect = rdr; wb_valid = wv; wb_rd = wr;
    #1;
    p1 = m_pend(r1, b1);
    p2 = m_pend(r2, b2);
    hz = v && ((u1 && p1) || (u2 && p2));
    st = v && we && (rd != 5'd0) && (model_cnt[rd] == CMAX);
    ei = v && !hz && !st && !rdr && (flush_left == 0);
    expv = {ei, v && (hz || st) && !rdr && (flush_left == 0), !ei, flush_left > 0,
            u1 && b1, u2 && b2, model_err};
  endtask

  task automatic tick();
    int d [32];
    @(posedge clk);
    for (int r = 0; r < 32; r++) d[r] = 0;
    if (expv[6] && id_rd_we && id_rd != 5'd0) d[id_rd]++;
    if (wb_valid && wb_rd != 5'd0) begin
      if (model_cnt[wb_rd] == 0) model_err = 1'b1;
      d[wb_rd]--;
    end
    for (int r = 0; r < 32; r++) model_cnt[r] = (model_cnt[r] + d[r] < 0) ? 0 : model_cnt[r] + d[r];
    if (ex_redirect) flush_left = FLUSH_CYCLES;
    else if (flush_left > 0) flush_left--;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    id_valid = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_rd_we = 0; ex_redirect = 0; wb_valid = 0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0; id_valid = 1'b1; id_use_rs1 = 1'b1; id_rs1 = 5'd4;
    #1;
    tests++;
    if ({issue, stall_if, flush_if_id, fwd_rs1, fwd_rs2, sb_err, dbg_state} !== 7'b1000000) begin
      fails++;
      $display("FAIL reset_outputs got=%b want=1000000",
               {issue, stall_if, flush_if_id, fwd_rs1, fwd_rs2, sb_err, dbg_state});
    end
    do_reset();
  endtask

  task automatic test_reset_mid_flush();
    do_reset();
    set_in(1, 0, 0, 0, 0, 0, 0, 1, 0, 0); tick();
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tests++;
    if (flush_if_id !== 1'b1) begin fails++; $display("FAIL mid_flush_pre got=%b want=1", flush_if_id); end
    rst = 1'b0;
    #1;
    tests++;
    if (flush_if_id !== 1'b0) begin fails++; $display("FAIL mid_flush_async got=%b want=0", flush_if_id); end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tests++;
    if (issue !== 1'b1 || sb_err !== 1'b0 || flush_if_id !== 1'b0) begin
      fails++; $display("FAIL mid_flush_after issue=%b sb_err=%b flush=%b want 1 0 0", issue, sb_err, flush_if_id);
    end
    tick();
  endtask

  task automatic test_raw();
    int icyc;
    icyc = BYP ? 3 : 4;
    do_reset();
    set_in(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
    tests++;
    if (issue !== 1'b1) begin fails++; $display("FAIL raw_writer issue=%b want=1", issue); end
    tick();
    for (int i = 1; i <= icyc; i++) begin
      set_in(1, 5, 0, 1, 0, 0, 0, 0, i == 3, 5);
      tests++;
      if ({issue, stall_if, bubble_id_ex, fwd_rs1} !== {i == icyc, i != icyc, i != icyc, BYP && i == icyc}) begin
        fails++;
        $display("FAIL raw_cycle%0d issue/stall/bubble/fwd=%b want=%b", i,
                 {issue, stall_if, bubble_id_ex, fwd_rs1}, {i == icyc, i != icyc, i != icyc, BYP && i == icyc});
      end
      tests++;
      if (obs !== expv) begin fails++; $display("FAIL raw_model cycle%0d got=%b want=%b", i, obs, expv); end
      tick();
    end
  endtask

  task automatic test_x0();
    do_reset();
    set_in(1, 0, 0, 0, 0, 0, 1, 0, 0, 0); tick();
    set_in(1, 0, 0, 1, 1, 0, 1, 0, 0, 0);
    tests++;
    if (issue !== 1'b1 || stall_if !== 1'b0) begin
      fails++; $display("FAIL x0_read issue=%b stall=%b want 1 0", issue, stall_if);
    end
    tick();
  endtask

  task automatic test_flush();
    do_reset();
    set_in(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    tests++;
    if ({issue, stall_if, bubble_id_ex, flush_if_id} !== 4'b0010) begin
      fails++; $display("FAIL redirect_cycle got=%b want=0010", {issue, stall_if, bubble_id_ex, flush_if_id});
    end
    tick();
    for (int k = 1; k <= FLUSH_CYCLES + 1; k++) begin
      set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tests++;
      if ({flush_if_id, issue} !== {k <= FLUSH_CYCLES, k > FLUSH_CYCLES}) begin
        fails++; $display("FAIL flush_k%0d flush/issue=%b want=%b", k, {flush_if_id, issue},
                          {k <= FLUSH_CYCLES, k > FLUSH_CYCLES});
      end
      tick();
    end
    set_in(1, 0, 0, 0, 0, 0, 0, 1, 0, 0); tick();
    set_in(1, 0, 0, 0, 0, 0, 0, 1, 0, 0); tick();
    for (int k = 1; k <= FLUSH_CYCLES + 1; k++) begin
      set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tests++;
      if (flush_if_id !== (k <= FLUSH_CYCLES) || dbg_state !== (k <= FLUSH_CYCLES)) begin
        fails++; $display("FAIL reflush_k%0d flush=%b dbg=%b want=%b", k, flush_if_id, dbg_state, k <= FLUSH_CYCLES);
      end
      tick();
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < CMAX; i++) begin
      set_in(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
      tests++;
      if (issue !== 1'b1) begin fails++; $display("FAIL sat_fill%0d issue=%b want=1", i, issue); end
      tick();
    end
    for (int i = 1; i <= 4; i++) begin
      set_in(1, 0, 0, 0, 0, 7, 1, 0, i == 3, 7);
      tests++;
      if ({issue, stall_if} !== {i == 4, i != 4}) begin
        fails++; $display("FAIL sat_cycle%0d issue/stall=%b want=%b", i, {issue, stall_if}, {i == 4, i != 4});
      end
      tick();
    end
  endtask

  task automatic test_underflow();
    do_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 9);
    tests++;
    if (sb_err !== 1'b0) begin fails++; $display("FAIL underflow_pre sb_err=%b want=0", sb_err); end
    tick();
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tests++;
      if (sb_err !== 1'b1) begin fails++; $display("FAIL underflow_sticky%0d sb_err=%b want=1", i, sb_err); end
      tick();
    end
    set_in(1, 9, 0, 1, 0, 0, 0, 0, 0, 0);
    tests++;
    if (issue !== 1'b1) begin fails++; $display("FAIL underflow_cnt0 issue=%b want=1", issue); end
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_in(1, 0, 0, 0, 0, 3, 1, 0, 0, 0); tick();
    set_in(1, 0, 0, 0, 0, 3, 1, 0, 1, 3);
    tests++;
    if (issue !== 1'b1) begin fails++; $display("FAIL same_cycle_issue issue=%b want=1", issue); end
    tick();
    set_in(1, 3, 0, 1, 0, 0, 0, 0, 0, 0);
    tests++;
    if ({stall_if, sb_err} !== 2'b10) begin
      fails++; $display("FAIL same_cycle_cnt stall/sb_err=%b want=10", {stall_if, sb_err});
    end
    tick();
    set_in(1, 3, 0, 1, 0, 0, 0, 0, 1, 3); tick();
    set_in(1, 3, 0, 1, 0, 0, 0, 0, 0, 0);
    tests++;
    if (issue !== 1'b1) begin fails++; $display("FAIL same_cycle_drain issue=%b want=1", issue); end
    tick();
  endtask

  task automatic test_random();
    logic [4:0] wr;
    logic wv;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      wr = 5'($urandom_range(0, 6));
      wv = (model_cnt[wr] > 0 && $urandom_range(0, 2) != 0) || ($urandom_range(0, 40) == 0);
      set_in($urandom_range(0, 3) != 0, 5'($urandom_range(0, 6)), 5'($urandom_range(0, 6)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 6)),
             1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0, wv, wr);
      tests++;
      if (obs !== expv) begin fails++; $display("FAIL random_step%0d got=%b want=%b", n, obs, expv); end
      tick();
    end
  endtask

  initial begin
    model_reset();
    expv = '0;
    test_reset();
    test_reset_mid_flush();
    test_raw();
    test_x0();
    test_flush();
    test_saturation();
    test_underflow();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
